// File: rtl/int_sched_if.sv
// rtl/int_sched_if.sv - processor port bus between the CPU and the interrupt scheduler
interface int_sched_if;
    logic [7:0] address;
    logic [7:0] value_in;
    logic       wen;
    logic       ren;
    logic [7:0] port_out;

    modport master (
        output address,
        output value_in,
        output wen,
        output ren,
        input  port_out
    );

    modport slave (
        input  address,
        input  value_in,
        input  wen,
        input  ren,
        output port_out
    );
endinterface

// File: rtl/int_sched.sv
// rtl/int_sched.sv - 8-source interrupt scheduler (INT_SCHED_ROUND_ROBIN_EN selects round-robin arbitration)
module int_sched #(
    parameter logic [7:0] ADDR_MASK = 8'h10,
    parameter logic [7:0] ADDR_PEND = 8'h11,
    parameter logic [7:0] ADDR_VEC  = 8'h12,
    parameter logic [7:0] ADDR_EOI  = 8'h13
) (
    input  logic        clk,
    input  logic        rst,
    int_sched_if.slave  bus,
    input  logic [7:0]  irq_in,
    output logic [7:0]  irq_ack_out,
    output logic        interrupt,
    input  logic        interrupt_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        EOI     = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_mask;
    logic [2:0] r_vec;
    logic [7:0] r_port_out;
    logic [7:0] w_pend;
    logic       w_any;
    logic [2:0] w_win;
    logic       w_mask_wr;
    logic       w_eoi_wr;

    assign w_pend    = irq_in & r_mask;
    assign w_any     = |w_pend;
    assign w_mask_wr = bus.wen && (bus.address == ADDR_MASK);
    assign w_eoi_wr  = bus.wen && (bus.address == ADDR_EOI);
    assign bus.port_out = r_port_out;

`ifdef INT_SCHED_ROUND_ROBIN_EN
    logic [2:0] r_last;

    // Round-robin pick: scan upward from the source after the last grant, wrapping at 7
    always_comb begin
        logic [2:0] idx;
        logic       found;
        w_win = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = r_last + 3'd1 + 3'(i);
            if (!found && w_pend[idx]) begin
                w_win = idx;
                found = 1'b1;
            end
        end
    end

    // Remember the granted source so the next search starts just past it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 3'd7;
        end else if (r_state == IDLE && w_any) begin
            r_last <= w_win;
        end
    end
`else
    // Fixed priority pick: the lowest pending index wins
    always_comb begin
        w_win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_win = 3'(i);
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs; EOI never arbitrates so the source gets a cycle to drop its request
    always_comb begin
        w_next      = r_state;
        interrupt   = 1'b0;
        irq_ack_out = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                interrupt = 1'b1;
                if (interrupt_ack) begin
                    w_next = SERVICE;
                end
            end
            SERVICE: begin
                if (w_eoi_wr) begin
                    w_next = EOI;
                end
            end
            EOI: begin
                // A reset landing on the EOI cycle suppresses the pulse entirely
                if (!rst) begin
                    irq_ack_out = 8'h01 << r_vec;
                end
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the winning source on the IDLE->REQ transition; held through the whole sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec <= 3'd0;
        end else if (r_state == IDLE && w_any) begin
            r_vec <= w_win;
        end
    end

    // Mask register; arbitration in the same cycle still sees the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= 8'h00;
        end else if (w_mask_wr) begin
            r_mask <= bus.value_in;
        end
    end

    // Registered read data, held when no read is in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_out <= 8'h00;
        end else if (bus.ren) begin
            case (bus.address)
                ADDR_MASK: r_port_out <= r_mask;
                ADDR_PEND: r_port_out <= w_pend;
                ADDR_VEC:  r_port_out <= {(r_state == REQ) || (r_state == SERVICE), 4'b0000, r_vec};
                default:   r_port_out <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_int_sched.sv
// tb/tb_int_sched.sv - table-driven self-checking bench for int_sched
module tb_int_sched;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic [7:0] irq_ack_out;
    logic       interrupt;
    logic       interrupt_ack;

    int checks;
    int errors;

    int_sched_if bus ();

    int_sched dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .irq_in        (irq_in),
        .irq_ack_out   (irq_ack_out),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] addr;
        logic [7:0] val;
        logic       wen;
        logic       ren;
        logic [7:0] irq;
        logic       iack;
        logic [7:0] e_po;
        logic       e_int;
        logic [7:0] e_ack;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic r, input logic [7:0] a, input logic [7:0] v,
                                input logic w, input logic rd, input logic [7:0] irq_v,
                                input logic ia, input logic [7:0] po, input logic it,
                                input logic [7:0] ak);
        vec_t t;
        t.rst = r; t.addr = a; t.val = v; t.wen = w; t.ren = rd; t.irq = irq_v; t.iack = ia;
        t.e_po = po; t.e_int = it; t.e_ack = ak;
        return t;
    endfunction

    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] v,
                         input logic w, input logic rd, input logic [7:0] irq_v, input logic ia);
        rst           = r;
        bus.address   = a;
        bus.value_in  = v;
        bus.wen       = w;
        bus.ren       = rd;
        irq_in        = irq_v;
        interrupt_ack = ia;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [7:0] po, input logic it,
                              input logic [7:0] ak);
        check({name, " port_out"}, bus.port_out, po);
        check({name, " interrupt"}, {7'd0, interrupt}, {7'd0, it});
        check({name, " irq_ack_out"}, irq_ack_out, ak);
    endtask

    logic [2:0] exp_grant [3];

    initial begin
        checks = 0;
        errors = 0;
        apply(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        //           rst  addr   val    wen   ren   irq    iack  po     int   ack
        tbl[0]  = mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[1]  = mk(1'b0, 8'h10, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[2]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 8'h00, 1'b1, 8'h00);
        tbl[3]  = mk(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 8'h82, 1'b1, 8'h00);
        tbl[4]  = mk(1'b0, 8'h11, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 8'h04, 1'b1, 8'h00);
        tbl[5]  = mk(1'b0, 8'h13, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 8'h04, 1'b1, 8'h00);
        tbl[6]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 8'h04, 1'b0, 8'h00);
        tbl[7]  = mk(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'h04, 1'b1, 8'h82, 1'b0, 8'h00);
        tbl[8]  = mk(1'b0, 8'h13, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 8'h82, 1'b0, 8'h04);
        tbl[9]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h82, 1'b0, 8'h00);
        tbl[10] = mk(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h02, 1'b0, 8'h00);
        tbl[11] = mk(1'b0, 8'h10, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 8'h00);
        tbl[12] = mk(1'b0, 8'h11, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[13] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[14] = mk(1'b0, 8'h10, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[15] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 8'h00);
        tbl[16] = mk(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 8'h00);
        tbl[17] = mk(1'b0, 8'h11, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00);
        tbl[18] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
        tbl[19] = mk(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h84, 1'b0, 8'h00);
        tbl[20] = mk(1'b0, 8'h13, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h84, 1'b0, 8'h10);
        tbl[21] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h84, 1'b0, 8'h00);
        tbl[22] = mk(1'b0, 8'h10, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[23] = mk(1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h00);
        tbl[24] = mk(1'b1, 8'h10, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[25] = mk(1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].rst, tbl[i].addr, tbl[i].val, tbl[i].wen, tbl[i].ren, tbl[i].irq, tbl[i].iack);
            check_outs($sformatf("vec%0d", i), tbl[i].e_po, tbl[i].e_int, tbl[i].e_ack);
        end

        // Mask write and arbitration in the same cycle: the old (zero) mask applies
        apply(1'b0, 8'h10, 8'hFF, 1'b1, 1'b0, 8'h01, 1'b0);
        check_outs("oldmask", 8'h00, 1'b0, 8'h00);
        apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
        check_outs("newmask", 8'h00, 1'b1, 8'h00);
        apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1);
        apply(1'b0, 8'h13, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        check_outs("oldmask eoi", 8'h00, 1'b0, 8'h01);
        apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // Three back-to-back services with sources 0 and 7 held, at minimum spacing
`ifdef INT_SCHED_ROUND_ROBIN_EN
        exp_grant[0] = 3'd0; exp_grant[1] = 3'd7; exp_grant[2] = 3'd0;
`else
        exp_grant[0] = 3'd0; exp_grant[1] = 3'd0; exp_grant[2] = 3'd0;
`endif
        apply(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b0, 8'h10, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0);
            check($sformatf("rr%0d interrupt", k), {7'd0, interrupt}, 8'h01);
            apply(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0);
            check($sformatf("rr%0d vec", k), bus.port_out, {5'b10000, exp_grant[k]});
            apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1);
            apply(1'b0, 8'h13, 8'h00, 1'b1, 1'b0, 8'h81, 1'b0);
            check($sformatf("rr%0d ack", k), irq_ack_out, 8'h01 << exp_grant[k]);
            apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0);
            check($sformatf("rr%0d gap", k), {irq_ack_out[7:1], interrupt}, 8'h00);
        end

        // Reset while in SERVICE with an EOI write pending: abort, no pulse
        apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0);
        apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1);
        apply(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
        check("svc vec", bus.port_out, 8'h81);
        apply(1'b1, 8'h13, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0);
        check_outs("svc rst", 8'h00, 1'b0, 8'h00);
        apply(1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0);
        check("svc rst mask", bus.port_out, 8'h00);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0);
            check_outs($sformatf("post rst%0d", k), 8'h00, 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 SHALL have parameter ADDR_MASK, default 8'h10, port address of the interrupt mask register (write/read).
REQ-002 SHALL have parameter ADDR_PEND, default 8'h11, port address of the masked pending register (read only).
REQ-003 SHALL have parameter ADDR_VEC, default 8'h12, port address of the vector register (read only).
REQ-004 SHALL have parameter ADDR_EOI, default 8'h13, port address of the end-of-interrupt strobe (write only, data ignored).
REQ-005 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port address, input, 8, port address from the processor.
REQ-008 SHALL have port value_in, input, 8, write data.
REQ-009 SHALL have port wen, input, 1, write strobe.
REQ-010 SHALL have port ren, input, 1, read strobe.
REQ-011 SHALL have port port_out, output, 8, registered read data, fed to the input-port mux.
REQ-012 SHALL have port irq_in, input, 8, level interrupt requests; bit i is held high by source i until it is acknowledged.
REQ-013 SHALL have port irq_ack_out, output, 8, one-cycle per-source acknowledge pulses.
REQ-014 SHALL have port interrupt, output, 1, interrupt line to the processor.
REQ-015 SHALL have port interrupt_ack, input, 1, processor interrupt acknowledge, one-cycle pulse.

Function
REQ-016 SHALL update mask to value_in on wen with address==ADDR_MASK.
REQ-017 SHALL define pend = irq_in & mask, evaluated combinationally from the current cycle's inputs.
REQ-018 SHALL implement FSM states IDLE, REQ, SERVICE, EOI.
REQ-019 IDLE: if pend!=0, SHALL latch the winning index into vec[2:0], set interrupt=1 and go to REQ on the next edge; otherwise SHALL stay in IDLE.
REQ-020 REQ: on interrupt_ack=1, SHALL clear interrupt and go to SERVICE; otherwise SHALL hold interrupt=1 and vec.
REQ-021 SERVICE: on wen with address==ADDR_EOI, SHALL go to EOI.
REQ-022 EOI: SHALL drive irq_ack_out = 1<<vec for exactly this one cycle, then return to IDLE; arbitration SHALL NOT occur in EOI, giving the source one cycle to drop its request.
REQ-023 Minimum spacing SHALL be: EOI write at edge N -> ack pulse in cycle N+1 -> earliest new interrupt assertion at edge N+2.
REQ-024 A read (ren=1) SHALL load port_out on the next edge with one of: mask (ADDR_MASK); pend (ADDR_PEND); {state==REQ or SERVICE, 4'b0, vec} (ADDR_VEC); 8'h00 for any other address. With ren=0, port_out SHALL hold its value.
REQ-025 Boundary: interrupt_ack outside REQ and EOI writes outside SERVICE SHALL be ignored.
REQ-026 Boundary: masking or dropping the granted source in REQ/SERVICE SHALL NOT cancel the grant; vec and the sequence SHALL complete normally.
REQ-027 Boundary: a write to ADDR_MASK and arbitration in the same cycle SHALL use the old mask.
REQ-028 Boundary: wen and ren in the same cycle SHALL both take effect independently.
REQ-029 irq_ack_out SHALL be one-hot or zero in every cycle.

Reset
REQ-030 On rst=1 at an edge: state=IDLE, mask=8'h00, vec=0, interrupt=0, irq_ack_out=0, port_out=8'h00, last=7.
REQ-031 Reset mid-sequence (REQ/SERVICE/EOI) SHALL abort without issuing any irq_ack_out pulse.
REQ-032 Reset SHALL dominate all other inputs in the same cycle.

Configuration
REQ-033 Macro INT_SCHED_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-034 Defined: round-robin; search starts at (last+1) mod 8 and wraps; last is updated to vec on entry to REQ.
REQ-035 Undefined: fixed priority, lowest set index wins; last is not implemented.

Verification
REQ-036 Scenario: reset, mask=8'hFF, irq_in=8'h04 -> interrupt high next edge; VEC read=8'h82; interrupt_ack -> interrupt low; EOI write -> irq_ack_out=8'h04 for one cycle.
REQ-037 Scenario: mask=8'h0F, irq_in=8'hF0 -> interrupt stays 0; PEND read=8'h00.
REQ-038 Scenario: irq_in=8'h81 held, three full service cycles -> fixed-priority build grants 0,0,0; round-robin build grants 0,7,0.
REQ-039 Scenario: EOI write while in REQ, and interrupt_ack while in SERVICE -> no state change and no ack pulse.
REQ-040 Scenario: rst asserted in SERVICE -> all outputs 0 and mask=8'h00 next cycle; no irq_ack_out pulse ever seen.
REQ-041 Scenario: mask cleared while in REQ -> sequence completes, and the ack pulse still goes to the latched vec.
